menu_cursor_sel: RTL

Parametrised menu cursor for the title and difficulty screens. It holds a selection index over N_OPT vertically stacked menu entries and moves it on edge-detected up/down button presses, with optional wrap-around. It also latches a confirmed choice on a select press. It draws a cross/square cursor glyph at the current entry and feeds the pixel mux alongside the text and maze layers.

---
 rtl/menu_cursor_sel.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/menu_cursor_sel.sv
// Menu cursor: holds a selection index over N_OPT stacked entries, moves it on
// up/down button edges (wrapping or saturating), latches a confirmed choice on
// a select edge, and draws a cross/square glyph at the current entry.
module menu_cursor_sel #(
   parameter int          N_OPT  = 3,
   parameter int          SEL_W  = 4,
   parameter int          X0     = 323,
   parameter int          Y0     = 302,
   parameter int          Y_STEP = 32,
   parameter int          ARM_L  = 10,
   parameter int          ARM_W  = 5,
   parameter int          CORE   = 7,
   parameter int          WRAP   = 1,
   parameter logic [2:0]  COLOR  = 3'b100
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             video_on,
   input  logic             btn_up,
   input  logic             btn_down,
   input  logic             btn_sel,
   input  logic [9:0]       pix_x,
   input  logic [9:0]       pix_y,
   output logic [SEL_W-1:0] sel_idx,
   output logic             sel_valid,
   output logic             locked,
   output logic             cursor_on,
   output logic [2:0]       cursor_rgb
);

   typedef enum logic [1:0] {IDLE = 2'd0, NAV = 2'd1, LOCKED = 2'd2} state_t;

   localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N_OPT - 1);
   localparam logic [SEL_W-1:0] ZERO_IDX = {SEL_W{1'b0}};
   localparam logic [SEL_W-1:0] ONE_IDX  = SEL_W'(1);

   // Horizontal bounds are fixed because every entry shares the same centre x.
   localparam logic [10:0] XW_LO = 11'(X0 - ARM_W);
   localparam logic [10:0] XW_HI = 11'(X0 + ARM_W);
   localparam logic [10:0] XL_LO = 11'(X0 - ARM_L);
   localparam logic [10:0] XL_HI = 11'(X0 + ARM_L);
   localparam logic [10:0] XC_LO = 11'(X0 - CORE);
   localparam logic [10:0] XC_HI = 11'(X0 + CORE);

   // Inclusive range test, avoids any signed subtraction against the pixel.
   function automatic logic in_rng(input logic [10:0] v, input logic [10:0] lo,
                                   input logic [10:0] hi);
      in_rng = (v >= lo) && (v <= hi);
   endfunction

   state_t           state_r, state_next_s;
   logic             up_prev_r, down_prev_r, sel_prev_r;
   logic             up_e_s, down_e_s, sel_e_s, nav_act_s;
   logic [SEL_W-1:0] sel_idx_r, idx_next_s, idx_move_s;
   logic             sel_valid_r, sel_pulse_s, locked_r;
   logic             cursor_on_r;
   logic [2:0]       cursor_rgb_r;
   logic [10:0]      cy_s, px_s, py_s;
   logic             hit_s;

   assign up_e_s    = btn_up   & ~up_prev_r;
   assign down_e_s  = btn_down & ~down_prev_r;
   assign sel_e_s   = btn_sel  & ~sel_prev_r;
   assign nav_act_s = (state_r == NAV) && enable;

   // Button history; held at 1 in reset so a button held through reset makes no edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         up_prev_r   <= 1'b1;
         down_prev_r <= 1'b1;
         sel_prev_r  <= 1'b1;
      end else begin
         up_prev_r   <= btn_up;
         down_prev_r <= btn_down;
         sel_prev_r  <= btn_sel;
      end
   end

   // Next-state logic: enable dropping always wins, select locks the choice.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (enable) state_next_s = NAV;
            else        state_next_s = IDLE;
         end
         NAV: begin
            if (!enable)      state_next_s = IDLE;
            else if (sel_e_s) state_next_s = LOCKED;
            else              state_next_s = NAV;
         end
         LOCKED: begin
            if (!enable) state_next_s = IDLE;
            else         state_next_s = LOCKED;
         end
         default: state_next_s = IDLE;
      endcase
   end

   // Index update: select beats up/down, simultaneous up+down cancels.
   always_comb begin
      idx_move_s  = sel_idx_r;
      sel_pulse_s = 1'b0;
      if (nav_act_s && sel_e_s) begin
         sel_pulse_s = 1'b1;
      end else if (nav_act_s && up_e_s && !down_e_s) begin
         if (sel_idx_r == ZERO_IDX) idx_move_s = (WRAP != 0) ? LAST_IDX : ZERO_IDX;
         else                       idx_move_s = sel_idx_r - ONE_IDX;
      end else if (nav_act_s && down_e_s && !up_e_s) begin
         if (sel_idx_r >= LAST_IDX) idx_move_s = (WRAP != 0) ? ZERO_IDX : LAST_IDX;
         else                       idx_move_s = sel_idx_r + ONE_IDX;
      end else begin
         idx_move_s = sel_idx_r;
      end
      // Unused codes above the last entry fold back to entry 0.
      if (idx_move_s > LAST_IDX) idx_next_s = ZERO_IDX;
      else                       idx_next_s = idx_move_s;
   end

   // Glyph hit test around the current entry centre.
   always_comb begin
      px_s  = {1'b0, pix_x};
      py_s  = {1'b0, pix_y};
      cy_s  = 11'(Y0) + 11'(sel_idx_r) * 11'(Y_STEP);
      hit_s = (in_rng(px_s, XW_LO, XW_HI) && in_rng(py_s, cy_s - 11'(ARM_L), cy_s + 11'(ARM_L)))
           || (in_rng(px_s, XL_LO, XL_HI) && in_rng(py_s, cy_s - 11'(ARM_W), cy_s + 11'(ARM_W)))
           || (in_rng(px_s, XC_LO, XC_HI) && in_rng(py_s, cy_s - 11'(CORE),  cy_s + 11'(CORE)));
   end

   // State, index, select pulse and lock flag registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= IDLE;
         sel_idx_r   <= ZERO_IDX;
         sel_valid_r <= 1'b0;
         locked_r    <= 1'b0;
      end else begin
         state_r     <= state_next_s;
         sel_idx_r   <= idx_next_s;
         sel_valid_r <= sel_pulse_s;
         locked_r    <= (state_next_s == LOCKED);
      end
   end

   // Registered pixel outputs, one cycle behind the pixel coordinates.
   always_ff @(posedge clk) begin
      if (reset) begin
         cursor_on_r  <= 1'b0;
         cursor_rgb_r <= 3'b000;
      end else begin
         cursor_on_r  <= hit_s & enable;
         cursor_rgb_r <= (video_on & enable & hit_s) ? COLOR : 3'b000;
      end
   end

   assign sel_idx    = sel_idx_r;
   assign sel_valid  = sel_valid_r;
   assign locked     = locked_r;
   assign cursor_on  = cursor_on_r;
   assign cursor_rgb = cursor_rgb_r;

endmodule
